// File: rtl/fp_div_issue.sv
// Issue/sequencing stage in front of the FP32 iterative divider: input FIFO, one op in flight, registered result slot.
// Optional macro DIV_TIMEOUT_EN adds a WAIT timeout that emits a quiet-NaN result and a DRAIN state.
module fp_div_issue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       div_en,
  output logic [31:0]                div_a,
  output logic [31:0]                div_b,
  input  logic                       div_ready,
  input  logic [31:0]                div_result,
  input  logic                       div_nan,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic                       out_nan,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_timeout,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fp_div_issue: DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("fp_div_issue: TIMEOUT must be at least 2");
  end

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      a;
    logic [31:0]      b;
  } entry_t;

`ifdef DIV_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;
  localparam int unsigned TMO_W = $clog2(TIMEOUT);
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
  logic             out_timeout_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
`endif

  state_t           state, state_d;
  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;
  logic             div_en_d, out_valid_d, out_nan_d;
  logic [31:0]      div_a_d, div_b_d, out_result_d;
  logic [TAG_W-1:0] out_tag_d;

  assign in_ready = (count != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign busy     = (state != S_IDLE) || (count != '0);

  // FIFO storage; pointers and occupancy live in the main register block
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{tag: in_tag, a: in_a, b: in_b};
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state;
    div_en_d     = 1'b0;
    div_a_d      = div_a;
    div_b_d      = div_b;
    out_valid_d  = out_valid;
    out_result_d = out_result;
    out_nan_d    = out_nan;
    out_tag_d    = out_tag;
    pop          = 1'b0;
`ifdef DIV_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt;
    out_timeout_d = out_timeout;
`endif
    if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state)
      S_IDLE: begin
        if (count != '0 && !out_valid) begin
          div_a_d  = head.a;
          div_b_d  = head.b;
          div_en_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef DIV_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A real completion on the timeout cycle takes priority
        if (div_ready) begin
          out_result_d = div_result;
          out_nan_d    = div_nan;
          out_tag_d    = head.tag;
          out_valid_d  = 1'b1;
          pop          = 1'b1;
          state_d      = S_IDLE;
`ifdef DIV_TIMEOUT_EN
          out_timeout_d = 1'b0;
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          out_result_d  = QNAN;
          out_nan_d     = 1'b1;
          out_tag_d     = head.tag;
          out_timeout_d = 1'b1;
          out_valid_d   = 1'b1;
          pop           = 1'b1;
          state_d       = S_DRAIN;
        end else begin
          tmo_cnt_d = tmo_cnt + TMO_W'(1);
`endif
        end
      end
`ifdef DIV_TIMEOUT_EN
      S_DRAIN: begin
        // The abandoned op still completes eventually; swallow that pulse
        if (div_ready) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      div_en     <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_nan    <= 1'b0;
      out_tag    <= '0;
    end else begin
      state      <= state_d;
      count      <= count + CNT_W'(push) - CNT_W'(pop);
      div_en     <= div_en_d;
      div_a      <= div_a_d;
      div_b      <= div_b_d;
      out_valid  <= out_valid_d;
      out_result <= out_result_d;
      out_nan    <= out_nan_d;
      out_tag    <= out_tag_d;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

`ifdef DIV_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt     <= '0;
      out_timeout <= 1'b0;
    end else begin
      tmo_cnt     <= tmo_cnt_d;
      out_timeout <= out_timeout_d;
    end
  end
`else
  assign out_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fp_div_issue.sv
// Self-checking bench for fp_div_issue: directed vector table, corner-case sequences and a random scoreboard run.
module tb_fp_div_issue;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid, in_ready;
  logic [31:0]      in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic             div_en;
  logic [31:0]      div_a, div_b;
  logic             div_ready;
  logic [31:0]      div_result;
  logic             div_nan;
  logic             out_valid, out_ready;
  logic [31:0]      out_result;
  logic             out_nan;
  logic [TAG_W-1:0] out_tag;
  logic             out_timeout;
  logic             busy;
  logic [CNT_W-1:0] count;

  fp_div_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .div_en(div_en), .div_a(div_a), .div_b(div_b),
    .div_ready(div_ready), .div_result(div_result), .div_nan(div_nan),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_nan(out_nan),
    .out_tag(out_tag), .out_timeout(out_timeout), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic             tmo;
  } op_t;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [7:0]       lat;
    logic [31:0]      exp_res;
    logic             exp_nan;
  } vec_t;

  int  checks = 0;
  int  errors = 0;
  op_t exp_q[$];

  int  div_lat      = 3;
  bit  div_silent   = 1'b0;
  bit  inject_stray = 1'b0;
  int  en_count     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behaviour of the downstream divider: {nan, quotient}
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C0_0000 && b == 32'h4000_0000) return {1'b0, 32'h4040_0000};
    if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return {1'b1, QNAN};
    return {1'b0, a ^ {b[7:0], b[31:8]}};
  endfunction

  // Divider model: responds div_lat cycles after div_en unless silent
  initial begin
    bit          pending;
    int          cnt;
    logic [31:0] hold_a, hold_b;
    logic [32:0] r;
    pending = 1'b0; cnt = 0; hold_a = '0; hold_b = '0;
    div_ready = 1'b0; div_result = '0; div_nan = 1'b0;
    forever begin
      @(negedge clk); #1;
      div_ready = 1'b0;
      if (!reset_n) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          chk("div_a_hold", div_a, hold_a);
          chk("div_b_hold", div_b, hold_b);
          chk("div_en_busy", 32'(div_en), 32'd0);
          if (cnt == 0) begin
            r = ref_div(hold_a, hold_b);
            div_result = r[31:0];
            div_nan    = r[32];
            div_ready  = 1'b1;
            pending    = 1'b0;
          end else begin
            cnt--;
          end
        end else if (div_en) begin
          en_count++;
          hold_a = div_a;
          hold_b = div_b;
          if (exp_q.size() != 0) begin
            chk("issue_a", div_a, exp_q[0].a);
            chk("issue_b", div_b, exp_q[0].b);
          end
          if (!div_silent) begin
            pending = 1'b1;
            cnt     = div_lat - 1;
          end
        end
        if (inject_stray) begin
          div_ready    = 1'b1;
          div_result   = 32'hDEAD_BEEF;
          div_nan      = 1'b0;
          inject_stray = 1'b0;
        end
      end
    end
  end

  // Output scoreboard: every accepted result matches the oldest pushed op
  initial begin
    op_t         e;
    logic [32:0] r;
    forever begin
      @(negedge clk); #2;
      if (reset_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          r = e.tmo ? {1'b1, QNAN} : ref_div(e.a, e.b);
          chk("sb_result", out_result, r[31:0]);
          chk("sb_nan", 32'(out_nan), 32'(r[32]));
          chk("sb_tag", 32'(out_tag), 32'(e.tag));
          chk("sb_timeout", 32'(out_timeout), 32'(e.tmo));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic push_one(input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input logic tmo);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
    #1;
    chk("push_ready", 32'(in_ready), 32'd1);
    if (in_ready) exp_q.push_back('{a: a, b: b, tag: tag, tmo: tmo});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int limit, output int t);
    t = 0;
    while (!out_valid && t < limit) begin
      @(negedge clk); #3;
      t++;
    end
    chk("out_valid_wait", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_drain(input int limit);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vec_t             vt [4];
    int               t, en0, acc, remaining;
    logic [31:0]      sr;
    logic [TAG_W-1:0] st;
    logic             sn;

    vt[0] = '{a: 32'h40C0_0000, b: 32'h4000_0000, tag: 4'd3,  lat: 8'd30, exp_res: 32'h4040_0000, exp_nan: 1'b0};
    vt[1] = '{a: 32'h7FC0_0000, b: 32'h3F80_0000, tag: 4'd5,  lat: 8'd2,  exp_res: 32'h7FC0_0000, exp_nan: 1'b1};
    vt[2] = '{a: 32'h3F80_0000, b: 32'h3F80_0000, tag: 4'd1,  lat: 8'd1,  exp_res: 32'h3FBF_8000, exp_nan: 1'b0};
    vt[3] = '{a: 32'h1234_5678, b: 32'h0000_0000, tag: 4'd15, lat: 8'd5,  exp_res: 32'h1234_5678, exp_nan: 1'b0};

    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_timeout", 32'(out_timeout), 32'd0);
    chk("rst_div_en", 32'(div_en), 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table: one op at a time, latency and field checks
    for (int i = 0; i < 4; i++) begin
      div_lat   = int'(vt[i].lat);
      out_ready = 1'b0;
      push_one(vt[i].a, vt[i].b, vt[i].tag, 1'b0);
      #3;
      chk("en_not_yet", 32'(div_en), 32'd0);
      @(negedge clk); #3;
      chk("en_issue", 32'(div_en), 32'd1);
      chk("div_a", div_a, vt[i].a);
      chk("div_b", div_b, vt[i].b);
      wait_out(300, t);
      chk("ready_to_out_latency", 32'(t), 32'(vt[i].lat) + 32'd1);
      chk("vec_result", out_result, vt[i].exp_res);
      chk("vec_nan", 32'(out_nan), 32'(vt[i].exp_nan));
      chk("vec_tag", 32'(out_tag), 32'(vt[i].tag));
      chk("vec_timeout", 32'(out_timeout), 32'd0);
      @(negedge clk); out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0; #3;
      chk("vec_consumed", 32'(out_valid), 32'd0);
    end

    // Fill past capacity while the divider is slow
    div_lat = 40; out_ready = 1'b1; acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_tag = TAG_W'(i);
      #1;
      if (in_ready) begin
        exp_q.push_back('{a: in_a, b: in_b, tag: in_tag, tmo: 1'b0});
        acc++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; #3;
    chk("full_accepted", 32'(acc), 32'd4);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    wait_drain(1000);

    // Output backpressure blocks the next issue
    div_lat = 3; out_ready = 1'b0;
    push_one($urandom, $urandom, 4'd6, 1'b0);
    push_one($urandom, $urandom, 4'd7, 1'b0);
    wait_out(100, t);
    sr = out_result; st = out_tag; sn = out_nan; en0 = en_count;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #3;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_result", out_result, sr);
      chk("bp_tag", 32'(out_tag), 32'(st));
      chk("bp_nan", 32'(out_nan), 32'(sn));
    end
    chk("bp_no_issue", 32'(en_count), 32'(en0));
    chk("bp_tag_first", 32'(st), 32'd6);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); #3;
    chk("bp_en_gap", 32'(div_en), 32'd0);
    @(negedge clk); #3;
    chk("bp_en_after", 32'(div_en), 32'd1);
    wait_drain(200);

    // Reset in the middle of WAIT, then a stray completion
    div_silent = 1'b1; out_ready = 1'b1; en0 = en_count;
    push_one($urandom, $urandom, 4'd2, 1'b0);
    repeat (6) @(negedge clk);
    #3;
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_issued", 32'(en_count), 32'(en0 + 1));
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    inject_stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #3;
      chk("rst_mid_count", 32'(count), 32'd0);
      chk("rst_mid_valid", 32'(out_valid), 32'd0);
    end
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_no_issue", 32'(en_count), 32'(en0 + 1));
    div_silent = 1'b0;

`ifdef DIV_TIMEOUT_EN
    // Divider never answers: timeout result, late pulse swallowed, next op normal
    div_silent = 1'b1; out_ready = 1'b0; en0 = en_count;
    push_one(32'h4040_0000, 32'h3F80_0000, 4'd9, 1'b1);
    @(negedge clk); #3;
    chk("tmo_issue", 32'(div_en), 32'd1);
    wait_out(200, t);
    chk("tmo_latency", 32'(t), 32'(TIMEOUT + 1));
    chk("tmo_result", out_result, QNAN);
    chk("tmo_nan", 32'(out_nan), 32'd1);
    chk("tmo_flag", 32'(out_timeout), 32'd1);
    chk("tmo_tag", 32'(out_tag), 32'd9);
    push_one(32'h4100_0000, 32'h4000_0000, 4'd10, 1'b0);
    div_silent = 1'b0;
    @(negedge clk); out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    chk("drain_no_issue", 32'(en_count), 32'(en0 + 1));
    @(negedge clk); inject_stray = 1'b1;
    wait_drain(100);
    chk("after_drain_issue", 32'(en_count), 32'(en0 + 2));
`endif

    // Random traffic against the scoreboard
    div_silent = 1'b0; remaining = 40; t = 0;
    while ((remaining > 0 || exp_q.size() != 0) && t < 4000) begin
      @(negedge clk);
      t++;
      div_lat   = int'($urandom_range(1, 8));
      out_ready = ($urandom_range(0, 3) != 0);
      if (remaining > 0 && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        in_a     = ($urandom_range(0, 7) == 0) ? 32'h7FC0_0001 : $urandom;
        in_b     = $urandom;
        in_tag   = TAG_W'($urandom);
        #1;
        if (in_ready) begin
          exp_q.push_back('{a: in_a, b: in_b, tag: in_tag, tmo: 1'b0});
          remaining--;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("rand_complete", 32'(exp_q.size() + remaining), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
